// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-port 32-bit arbiter and sequencer for a 256Kx16 async SRAM.
// Define SRAM_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_arb_ctrl #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [16:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_bmask,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [16:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_bmask,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LO, REC, HI, DONE} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic sel, hs, cnt_end, port, f_port, f_we, l_we, act, ph_hi, dq_oe;
    logic [16:0] l_addr, f_addr;
    logic [31:0] l_wdata, f_wdata;
    logic [3:0] l_bmask, f_bmask;
    logic [1:0] m2;
    logic [15:0] rd_lo, dq_out;
`ifdef SRAM_RR_ARB_EN
    logic last_port;
    assign sel = req1_valid && (!req0_valid || !last_port);
    always_ff @(posedge clk) last_port <= rst ? 1'b1 : (hs ? sel : last_port);
`else
    assign sel = req1_valid && !req0_valid;
`endif
    assign req0_ready = !rst && state == IDLE && !sel;
    assign req1_ready = !rst && state == IDLE && sel;
    assign hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    // Handshake-cycle fields come straight from the winner so the first phase starts next edge.
    assign f_port = hs ? sel : port;
    assign f_we = hs ? (sel ? req1_we : req0_we) : l_we;
    assign f_addr = hs ? (sel ? req1_addr : req0_addr) : l_addr;
    assign f_wdata = hs ? (sel ? req1_wdata : req0_wdata) : l_wdata;
    assign f_bmask = hs ? (sel ? req1_bmask : req0_bmask) : l_bmask;
    assign cnt_end = cnt == CW'(ACCESS_CYCLES - 1);
    assign act = state_d == LO || state_d == HI;
    assign ph_hi = state_d == HI;
    assign m2 = f_we ? (ph_hi ? f_bmask[3:2] : f_bmask[1:0]) : 2'b11;
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;
    always_comb begin
        state_d = state;
        cnt_d = '0;
        case (state)
            IDLE: if (hs) state_d = (!f_we || f_bmask[1:0] != 2'b00) ? LO : (f_bmask[3:2] != 2'b00) ? HI : DONE;
            LO: begin
                cnt_d = cnt_end ? '0 : cnt + CW'(1);
                if (cnt_end) state_d = (l_we && l_bmask[3:2] == 2'b00) ? DONE : REC;
            end
            REC: state_d = HI;
            HI: begin
                cnt_d = cnt_end ? '0 : cnt + CW'(1);
                if (cnt_end) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    // Strobes and bus drive are registered from the next state so they change only on edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N} <= 5'h1f;
            SRAM_ADDR <= '0;
            dq_oe <= 1'b0;
            dq_out <= '0;
            port <= 1'b0;
            l_we <= 1'b0;
            l_addr <= '0;
            l_wdata <= '0;
            l_bmask <= '0;
            rd_lo <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            SRAM_CE_N <= !act;
            SRAM_OE_N <= !(act && !f_we);
            SRAM_WE_N <= !(act && f_we);
            SRAM_LB_N <= !(act && m2[0]);
            SRAM_UB_N <= !(act && m2[1]);
            if (act) SRAM_ADDR <= {f_addr, ph_hi};
            dq_oe <= act && f_we;
            dq_out <= ph_hi ? f_wdata[31:16] : f_wdata[15:0];
            if (hs) begin
                port <= sel;
                l_we <= f_we;
                l_addr <= f_addr;
                l_wdata <= f_wdata;
                l_bmask <= f_bmask;
            end
            if (state == LO && cnt_end) rd_lo <= SRAM_DQ;
            rsp0_valid <= state_d == DONE && !f_port;
            rsp1_valid <= state_d == DONE && f_port;
            if (state == HI && cnt_end && !l_we && !port) rsp0_rdata <= {SRAM_DQ, rd_lo};
            if (state == HI && cnt_end && !l_we && port) rsp1_rdata <= {SRAM_DQ, rd_lo};
        end
    end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: scoreboard bench with an SRAM model (A=2) and a read-only pattern SRAM (A=1).
module tb_sram_arb_ctrl;
    logic clk = 1'b0, rst = 1'b1, mon_en = 1'b0;
    always #10 clk = ~clk;
    logic req0_valid, req0_we, req0_ready, rsp0_valid, req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [16:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
    logic [3:0] req0_bmask, req1_bmask;
    logic [17:0] sram_addr;
    wire [15:0] sram_dq;
    logic ce_n, oe_n, we_n, lb_n, ub_n;
    logic b1_valid, b1_ready, b_rsp0_valid, b_rsp1_valid, b_ce_n, b_oe_n, b_we_n, b_lb_n, b_ub_n, b_ready0;
    logic [16:0] b1_addr;
    logic [31:0] b_rsp0_rdata, b_rsp1_rdata;
    logic [17:0] b_addr;
    wire [15:0] dq_b;
    sram_arb_ctrl #(.ACCESS_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_bmask(req0_bmask), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_bmask(req1_bmask), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
        .SRAM_WE_N(we_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );
    sram_arb_ctrl #(.ACCESS_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(1'b0), .req0_we(1'b0), .req0_addr(17'd0), .req0_wdata(32'd0),
        .req0_bmask(4'd0), .req0_ready(b_ready0), .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .req1_valid(b1_valid), .req1_we(1'b0), .req1_addr(b1_addr), .req1_wdata(32'd0),
        .req1_bmask(4'd0), .req1_ready(b1_ready), .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .SRAM_ADDR(b_addr), .SRAM_DQ(dq_b), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n),
        .SRAM_WE_N(b_we_n), .SRAM_LB_N(b_lb_n), .SRAM_UB_N(b_ub_n)
    );
    // Released buses float high so any stray drive shows up as a non-FFFF value.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_dq[g]);
        pullup (dq_b[g]);
    end
    logic [15:0] mem [0:255];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
    assign dq_b = (!b_ce_n && !b_oe_n) ? (b_addr[15:0] ^ 16'ha5c3) : 16'hzzzz;
    always @(negedge clk) if (!ce_n && !we_n) begin
        if (!lb_n) mem[sram_addr[7:0]][7:0] <= sram_dq[7:0];
        if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
    int cyc = 0, checks = 0, errors = 0, rsp_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
        end
    endtask
    typedef struct {bit p; bit we; logic [31:0] rd; int tmin; int tmax;} exp_t;
    typedef struct {logic [17:0] a; logic [15:0] d; logic lb; logic ub; logic we;} act_t;
    exp_t sq[$];
    act_t lg[$];
    bit gl[$];
    int bq_t[$];
    logic [31:0] bq_d[$];
    logic [31:0] last_rd [2];
    exp_t em;
    always @(negedge clk) if (mon_en) begin
        if (rsp0_valid || rsp1_valid) begin
            rsp_cnt++;
            chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 0);
            chk("rsp_queue_nonempty", 32'(sq.size() > 0), 1);
            if (sq.size() > 0) begin
                em = sq.pop_front();
                chk("rsp_port", 32'(rsp1_valid), 32'(em.p));
                chk("rsp_cycle", (cyc >= em.tmin && cyc <= em.tmax) ? em.tmin : cyc, em.tmin);
                if (!em.we) last_rd[em.p] = em.rd;
                chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, last_rd[em.p]);
            end
        end
        if (we_n && oe_n) chk("dq_released", 32'(sram_dq), 32'h0000ffff);
        chk("oe_we_overlap", 32'(!oe_n && !we_n), 0);
        if (!ce_n) lg.push_back('{sram_addr, sram_dq, lb_n, ub_n, we_n});
        if (req0_valid && req0_ready) gl.push_back(1'b0);
        else if (req1_valid && req1_ready) gl.push_back(1'b1);
        chk("b_we_idle", 32'(b_we_n), 1);
        if (b_oe_n) chk("b_dq_released", 32'(dq_b), 32'h0000ffff);
        chk("b_rsp0_quiet", 32'(b_rsp0_valid), 0);
        if (b_rsp1_valid) begin
            bq_t.push_back(cyc);
            bq_d.push_back(b_rsp1_rdata);
        end
    end
    task automatic req(input bit p, input bit we, input logic [16:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic [31:0] rd, input int lmin, input int lmax, input bit push);
        exp_t e;
        bit got = 0;
        @(posedge clk);
        #1;
        if (p) {req1_valid, req1_we, req1_addr, req1_wdata, req1_bmask} = {1'b1, we, a, d, m};
        else {req0_valid, req0_we, req0_addr, req0_wdata, req0_bmask} = {1'b1, we, a, d, m};
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin
                got = 1;
                if (push) begin
                    e = '{p, we, rd, cyc + lmin, cyc + lmax};
                    sq.push_back(e);
                end
            end
        end
        chk("handshake", 32'(got), 1);
        @(posedge clk);
        #1;
        if (p) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 100 && sq.size() > 0; i++) @(negedge clk);
        chk("drain", sq.size(), 0);
    endtask
    logic [3:0] gexp;
    logic [31:0] bexp [3];
    int bhs [3];
    bit found;
    int n0;
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        {req0_valid, req0_we, req0_addr, req0_wdata, req0_bmask} = {1'b1, 1'b0, 17'd0, 32'd0, 4'd0};
        {req1_valid, req1_we, req1_addr, req1_wdata, req1_bmask} = {1'b1, 1'b0, 17'd0, 32'd0, 4'd0};
        b1_valid = 1'b0;
        b1_addr = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
        chk("rst_dq_z", 32'(sram_dq), 32'h0000ffff);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
        chk("rst_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
        chk("rst_rdata0", rsp0_rdata, 0);
        chk("rst_addr", 32'(sram_addr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready0_after_rst", 32'(req0_ready), 1);
        chk("ready1_after_rst", 32'(req1_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lg.delete();
        req(0, 1, 17'h10, 32'hdeadbeef, 4'hf, 0, 6, 6, 1);
        wait_done();
        chk("full_wr_active", lg.size(), 4);
        chk("full_wr_lo", {lg[0].a, lg[0].d[13:0]}, {18'h00020, 14'h3eef});
        chk("full_wr_lo_data", 32'(lg[0].d), 32'hbeef);
        chk("full_wr_hi", 32'(lg[3].a), 32'h21);
        chk("full_wr_hi_data", 32'(lg[3].d), 32'hdead);
        chk("full_wr_bytes", 32'({lg[0].lb, lg[0].ub, lg[0].we}), 0);
        req(0, 0, 17'h10, 0, 4'h0, 32'hdeadbeef, 6, 6, 1);
        wait_done();
        lg.delete();
        req(0, 1, 17'h11, 32'h12345678, 4'hc, 0, 3, 3, 1);
        wait_done();
        chk("hi_only_active", lg.size(), 2);
        chk("hi_only_addr", 32'(lg[0].a), 32'h23);
        chk("hi_only_data", 32'(lg[0].d), 32'h1234);
        chk("hi_only_bytes", 32'({lg[0].lb, lg[0].ub}), 0);
        lg.delete();
        req(1, 1, 17'h11, 32'haabbccdd, 4'h4, 0, 3, 3, 1);
        wait_done();
        chk("byte2_active", lg.size(), 2);
        chk("byte2_addr", 32'(lg[0].a), 32'h23);
        chk("byte2_lb_ub", 32'({lg[0].lb, lg[0].ub}), 32'b01);
        chk("byte2_data", 32'(lg[0].d), 32'haabb);
        lg.delete();
        req(0, 1, 17'h11, 32'hffffffff, 4'h0, 0, 1, 2, 1);
        wait_done();
        chk("nomask_active", lg.size(), 0);
        lg.delete();
        req(1, 1, 17'h11, 32'h00009988, 4'h3, 0, 3, 3, 1);
        wait_done();
        chk("lo_only_active", lg.size(), 2);
        chk("lo_only_addr", 32'(lg[0].a), 32'h22);
        chk("lo_only_data", 32'(lg[0].d), 32'h9988);
        req(1, 0, 17'h11, 0, 4'h0, 32'h12bb9988, 6, 6, 1);
        wait_done();
        gl.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) req(0, 1, 17'(32'h30 + i), 32'h5555_0000 + i, 4'hf, 0, 6, 6, 1);
            end
            begin
                for (int i = 0; i < 2; i++) req(1, 1, 17'(32'h40 + i), 32'h1111_0000 + i, 4'hf, 0, 6, 6, 1);
            end
        join
        wait_done();
`ifdef SRAM_RR_ARB_EN
        gexp = 4'b1010;
`else
        gexp = 4'b0000;
`endif
        chk("grant_count", gl.size(), 6);
        for (int i = 0; i < 4; i++) chk($sformatf("grant_%0d", i), 32'(gl[i]), 32'(gexp[i]));
        req(1, 0, 17'h41, 0, 4'h0, 32'h11110001, 6, 6, 1);
        wait_done();
        req(0, 0, 17'h33, 0, 4'h0, 32'h55550003, 6, 6, 1);
        wait_done();
        req(0, 1, 17'h50, 32'hcafef00d, 4'hf, 0, 0, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!we_n && sram_addr == 18'h000a1) found = 1;
        end
        chk("reached_hi", 32'(found), 1);
        rst = 1'b1;
        n0 = rsp_cnt;
        @(posedge clk);
        #1;
        chk("abort_strobes", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1f);
        chk("abort_dq_z", 32'(sram_dq), 32'h0000ffff);
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_rsp", rsp_cnt, n0);
        chk("abort_rdata_cleared", rsp0_rdata, 0);
        req(0, 0, 17'h10, 0, 4'h0, 32'hdeadbeef, 6, 6, 1);
        wait_done();
        bexp[0] = 32'ha7c2a7c3;
        bexp[1] = 32'ha7c0a7c1;
        bexp[2] = 32'ha7c6a7c7;
        @(posedge clk);
        #1;
        b1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b1_addr = 17'(32'h100 + k);
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (b1_ready) begin
                    found = 1;
                    bhs[k] = cyc;
                end
            end
            chk("b_handshake", 32'(found), 1);
            @(posedge clk);
            #1;
        end
        b1_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("b_rsp_count", bq_t.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b_rdata_%0d", k), bq_d[k], bexp[k]);
            chk($sformatf("b_latency_%0d", k), bq_t[k] - bhs[k], 4);
        end
        for (int k = 0; k < 2; k++) chk($sformatf("b_rsp_period_%0d", k), bq_t[k + 1] - bq_t[k], 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
